// File: rtl/keypad_scan_if.sv
// keypad_scan_if
//   Bundles the keypad pins and the decoded key outputs of keypad_scan.
//
//   Signals
//     KEY_COL   [3:0]  column lines from the keypad, active-low, asynchronous
//     KEY_ROW   [3:0]  registered row drive, active-low
//     key_code  [3:0]  code of the last accepted key (row*4 + col)
//     key_valid        one-cycle strobe for a newly accepted press
//     key_down         high from acceptance until debounced release
//
//   Strobe semantics: there is no ready/back-pressure. key_valid is high for
//   exactly one cp cycle per accepted press and key_code is already valid in
//   that cycle; a consumer that is not sampling in that cycle misses the
//   press. key_code holds its value until the next acceptance.
//
//   Modports
//     slave  : the scanner (reads KEY_COL, drives everything else)
//     master : the board / consumer side
interface keypad_scan_if;
   logic [3:0] KEY_COL;
   logic [3:0] KEY_ROW;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   modport slave (
      input  KEY_COL,
      output KEY_ROW,
      output key_code,
      output key_valid,
      output key_down
   );

   modport master (
      output KEY_COL,
      input  KEY_ROW,
      input  key_code,
      input  key_valid,
      input  key_down
   );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan
//   Scanned 4x4 matrix keypad reader. Walks an active-low row select, reads
//   the synchronized column lines back, debounces a single key and reports
//   its code with a one-cycle strobe.
//
//   Parameters
//     SCAN_DIV        cp cycles per scan tick (>= 4)
//     DEBOUNCE_TICKS  consecutive identical tick samples to accept a press
//                     or a release (>= 1)
//
//   Ports
//     cp         system clock, rising edge
//     rst        synchronous active-high reset
//     kp         keypad_scan_if.slave: KEY_COL in; KEY_ROW, key_code,
//                key_valid, key_down out
//     dbg_state  current FSM state (0 IDLE, 1 SCAN, 2 DEBOUNCE, 3 HELD)
module keypad_scan #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_TICKS = 10
) (
   input  logic          cp,
   input  logic          rst,
   keypad_scan_if.slave  kp,
   output logic [1:0]    dbg_state
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SCAN     = 2'd1,
      ST_DEBOUNCE = 2'd2,
      ST_HELD     = 2'd3
   } state_t;

   // Column synchronizer; idles at all-released.
   logic [3:0] col_m, col_s;

   always_ff @(posedge cp) begin
      if (rst) begin
         col_m <= 4'hF;
         col_s <= 4'hF;
      end else begin
         col_m <= kp.KEY_COL;
         col_s <= col_m;
      end
   end

   // Free-running scan divider.
   logic [DIV_W-1:0] div_q;
   logic             tick;

   assign tick = (div_q == DIV_LAST);

   always_ff @(posedge cp) begin
      if (rst)       div_q <= '0;
      else if (tick) div_q <= '0;
      else           div_q <= div_q + DIV_W'(1);
   end

   // Single-key decode: exactly one column low.
   logic       single;
   logic [1:0] col_idx;

   always_comb begin
      single  = 1'b1;
      col_idx = 2'd0;
      case (col_s)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: single  = 1'b0;
      endcase
   end

   // FSM state and registered outputs.
   state_t           state, state_nxt;
   logic [1:0]       r, r_nxt;
   logic [3:0]       col_l, col_l_nxt;
   logic [3:0]       code_l, code_l_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [CNT_W-1:0] rel, rel_nxt, rel_inc;
   logic [3:0]       key_row_q, key_row_nxt;
   logic [3:0]       key_code_q, key_code_nxt;
   logic             key_valid_q, key_valid_nxt;
   logic             key_down_q, key_down_nxt;

   // Both counters stay below CNT_DONE while in use, so +1 cannot wrap.
   assign cnt_inc = cnt + CNT_ONE;
   assign rel_inc = rel + CNT_ONE;

   always_ff @(posedge cp) begin
      if (rst) begin
         state       <= ST_IDLE;
         r           <= 2'd0;
         col_l       <= 4'hF;
         code_l      <= 4'h0;
         cnt         <= '0;
         rel         <= '0;
         key_row_q   <= 4'b0000;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         state       <= state_nxt;
         r           <= r_nxt;
         col_l       <= col_l_nxt;
         code_l      <= code_l_nxt;
         cnt         <= cnt_nxt;
         rel         <= rel_nxt;
         key_row_q   <= key_row_nxt;
         key_code_q  <= key_code_nxt;
         key_valid_q <= key_valid_nxt;
         key_down_q  <= key_down_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      r_nxt         = r;
      col_l_nxt     = col_l;
      code_l_nxt    = code_l;
      cnt_nxt       = cnt;
      rel_nxt       = rel;
      key_code_nxt  = key_code_q;
      key_valid_nxt = 1'b0;
      key_down_nxt  = key_down_q;

      if (tick) begin
         case (state)
            ST_IDLE: begin
               if (col_s != 4'hF) begin
                  state_nxt = ST_SCAN;
                  r_nxt     = 2'd0;
               end
            end
            ST_SCAN: begin
               if (single) begin
                  col_l_nxt  = col_s;
                  code_l_nxt = {r, col_idx};
                  cnt_nxt    = CNT_ONE;
                  // A one-tick debounce accepts on the discovering tick.
                  if (CNT_DONE == CNT_ONE) begin
                     key_code_nxt  = {r, col_idx};
                     key_valid_nxt = 1'b1;
                     key_down_nxt  = 1'b1;
                     rel_nxt       = '0;
                     state_nxt     = ST_HELD;
                  end else begin
                     state_nxt = ST_DEBOUNCE;
                  end
               end else if (r == 2'd3) begin
                  // No key or a ghost pattern on every row: rescan from IDLE.
                  state_nxt = ST_IDLE;
               end else begin
                  r_nxt = r + 2'd1;
               end
            end
            ST_DEBOUNCE: begin
               if (col_s == col_l) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     key_code_nxt  = code_l;
                     key_valid_nxt = 1'b1;
                     key_down_nxt  = 1'b1;
                     rel_nxt       = '0;
                     state_nxt     = ST_HELD;
                  end
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_HELD: begin
               // Only the held row is driven, so keys on other rows are
               // invisible here; any low column keeps the key held.
               if (col_s == 4'hF) begin
                  if (rel_inc == CNT_DONE) begin
                     rel_nxt      = '0;
                     key_down_nxt = 1'b0;
                     state_nxt    = ST_IDLE;
                  end else begin
                     rel_nxt = rel_inc;
                  end
               end else begin
                  rel_nxt = '0;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end

      // Row drive follows the next state; DEBOUNCE and HELD keep the row
      // that was being scanned when the key was found.
      case (state_nxt)
         ST_IDLE: key_row_nxt = 4'b0000;
         ST_SCAN: key_row_nxt = ~(4'b0001 << r_nxt);
         default: key_row_nxt = key_row_q;
      endcase
   end

   assign kp.KEY_ROW   = key_row_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_down  = key_down_q;
   assign dbg_state    = state;

endmodule
